// File: rtl/nn_pkg.sv
`default_nettype none
// ============================================================================
// Module      : nn_pkg
// Description : Shared types and helpers for the layer MAC sequencer:
//               FSM state encoding, default datapath widths, network layer
//               sizes, weight-base helper and the shift/saturate helper.
// Options     : none (RELU_EN is consumed by nn_mac_unit)
// Revision    : 1.0 - initial release
// ============================================================================
package nn_pkg;

   localparam int NN_DATA_W = 16;
   localparam int NN_FRAC_W = 8;
   localparam int NN_ACC_W  = 40;
   localparam int NN_ADDR_W = 10;

   localparam int NN_N_IN = 4;
   localparam int NN_N_L0 = 8;
   localparam int NN_N_L1 = 8;
   localparam int NN_N_L2 = 2;

   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      LOAD  = 3'd1,
      READ  = 3'd2,
      DRAIN = 3'd3,
      WRITE = 3'd4,
      FIN   = 3'd5
   } state_t;

   // First weight address of a layer; weights are stored layer after layer,
   // neuron-major, each neuron's fan-in contiguous.
   function automatic int weight_base(input int layer_idx, input int n_in,
                                      input int n_l0, input int n_l1);
      case (layer_idx)
         0:       return 0;
         1:       return n_in * n_l0;
         default: return n_in * n_l0 + n_l0 * n_l1;
      endcase
   endfunction

   // Arithmetic shift right by frac_w, then clamp to a signed data_w range.
   // Operates on a 64-bit container so any accumulator width up to 64 fits;
   // the caller truncates the (in-range) result to its data width.
   function automatic logic signed [63:0] shift_saturate(input logic signed [63:0] acc,
                                                         input int frac_w,
                                                         input int data_w);
      logic signed [63:0] sh;
      logic signed [63:0] max_v;
      logic signed [63:0] min_v;
      sh    = acc >>> frac_w;
      max_v = (64'sd1 <<< (data_w - 1)) - 64'sd1;
      min_v = -max_v - 64'sd1;
      if (sh > max_v)
         return max_v;
      else if (sh < min_v)
         return min_v;
      else
         return sh;
   endfunction

endpackage
`default_nettype wire

// File: rtl/nn_mac_unit.sv
`default_nettype none
// ============================================================================
// Module      : nn_mac_unit
// Description : Signed multiply-accumulate with synchronous clear/enable,
//               followed by arithmetic shift and saturation of the result.
// Options     : RELU_EN - when defined, a negative saturated result is forced
//               to zero while relu is high.
// Ports       : clk    - clock
//               reset  - asynchronous active-low reset
//               clr    - clear accumulator (wins over en)
//               en     - accumulate w*a
//               relu   - apply ReLU to the result (only with RELU_EN)
//               w, a   - signed Q-format operands
//               result - shifted, saturated (optionally rectified) output
// Revision    : 1.0 - initial release
// ============================================================================
module nn_mac_unit
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int FRAC_W = NN_FRAC_W,
   parameter int ACC_W  = NN_ACC_W
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic              relu,
   input  logic [DATA_W-1:0] w,
   input  logic [DATA_W-1:0] a,
   output logic [DATA_W-1:0] result
);

   logic signed [2*DATA_W-1:0] prod;
   logic signed [ACC_W-1:0]    acc_d;
   logic signed [ACC_W-1:0]    acc_q;
   logic        [DATA_W-1:0]   sat;

   always_comb begin
      prod  = $signed(w) * $signed(a);
      acc_d = acc_q;
      if (clr)
         acc_d = '0;
      else if (en)
         acc_d = acc_q + {{(ACC_W-2*DATA_W){prod[2*DATA_W-1]}}, prod};
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset)
         acc_q <= '0;
      else
         acc_q <= acc_d;
   end

   always_comb begin
      sat = DATA_W'(shift_saturate(64'(acc_q), FRAC_W, DATA_W));
   end

`ifdef RELU_EN
   always_comb begin
      result = (relu && sat[DATA_W-1]) ? '0 : sat;
   end
`else
   logic unused_relu;
   assign unused_relu = relu;
   always_comb begin
      result = sat;
   end
`endif

endmodule
`default_nettype wire

// File: rtl/layer_mac_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : layer_mac_sequencer
// Description : Responder of the layer start/done handshake. For the requested
//               layer it reads every weight/activation pair, accumulates per
//               neuron, then writes the scaled, saturated result into the
//               opposite activation bank, and pulses done when finished.
// Options     : RELU_EN - rectify outputs of layers 0 and 1 (see nn_mac_unit).
// Ports       : clk, reset (async active-low)
//               start/layer      - layer request, layer 3 = no-op
//               busy/done        - status and one-cycle completion pulse
//               w_addr/w_rdata   - weight RAM, data one cycle after address
//               a_addr/a_rdata   - activation RAM read, MSB = bank
//               rd_en            - read strobe for both RAMs
//               o_addr/o_wdata/o_we - activation write port, MSB = bank
// Revision    : 1.0 - initial release
// ============================================================================
module layer_mac_sequencer
   import nn_pkg::*;
#(
   parameter int DATA_W = NN_DATA_W,
   parameter int FRAC_W = NN_FRAC_W,
   parameter int ACC_W  = NN_ACC_W,
   parameter int ADDR_W = NN_ADDR_W,
   parameter int N_IN   = NN_N_IN,
   parameter int N_L0   = NN_N_L0,
   parameter int N_L1   = NN_N_L1,
   parameter int N_L2   = NN_N_L2
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [1:0]        layer,
   output logic              busy,
   output logic              done,
   output logic [ADDR_W-1:0] w_addr,
   input  logic [DATA_W-1:0] w_rdata,
   output logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_rdata,
   output logic              rd_en,
   output logic [ADDR_W-1:0] o_addr,
   output logic [DATA_W-1:0] o_wdata,
   output logic              o_we
);

   localparam int W_BASE1 = weight_base(1, N_IN, N_L0, N_L1);
   localparam int W_BASE2 = weight_base(2, N_IN, N_L0, N_L1);
   localparam int CNT_W   = ADDR_W - 1;

   state_t            state_q, state_d;
   logic [1:0]        layer_q, layer_d;
   logic [CNT_W-1:0]  j_q, j_d;
   logic [CNT_W-1:0]  i_q, i_d;
   logic              acc_en_q, acc_en_d;

   logic [CNT_W-1:0]  fan_in;
   logic [CNT_W-1:0]  fan_out;
   logic [ADDR_W-1:0] w_base;
   logic              acc_clr;
   logic              relu_layer;
   logic [DATA_W-1:0] mac_result;

   // Per-layer geometry; layer 3 never reaches the datapath states.
   always_comb begin
      fan_in  = CNT_W'(N_IN);
      fan_out = CNT_W'(N_L0);
      w_base  = '0;
      case (layer_q)
         2'd1: begin
            fan_in  = CNT_W'(N_L0);
            fan_out = CNT_W'(N_L1);
            w_base  = ADDR_W'(W_BASE1);
         end
         2'd2: begin
            fan_in  = CNT_W'(N_L1);
            fan_out = CNT_W'(N_L2);
            w_base  = ADDR_W'(W_BASE2);
         end
         default: ;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q  <= IDLE;
         layer_q  <= '0;
         j_q      <= '0;
         i_q      <= '0;
         acc_en_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         layer_q  <= layer_d;
         j_q      <= j_d;
         i_q      <= i_d;
         acc_en_q <= acc_en_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d  = state_q;
      layer_d  = layer_q;
      j_d      = j_q;
      i_d      = i_q;
      // RAM data lags the address by one cycle, so the read strobe delayed
      // by one cycle marks the cycles in which w_rdata/a_rdata are valid.
      acc_en_d = (state_q == READ);
      case (state_q)
         IDLE: begin
            if (start) begin
               layer_d = layer;
               state_d = (layer == 2'd3) ? FIN : LOAD;
            end
         end
         LOAD: begin
            j_d     = '0;
            i_d     = '0;
            state_d = READ;
         end
         READ: begin
            i_d = i_q + 1'b1;
            if (i_q == fan_in - 1'b1)
               state_d = DRAIN;
         end
         DRAIN: state_d = WRITE;
         WRITE: begin
            if (j_q == fan_out - 1'b1) begin
               state_d = FIN;
            end else begin
               j_d     = j_q + 1'b1;
               i_d     = '0;
               state_d = READ;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Outputs; addresses and write data are held at zero outside their strobes.
   always_comb begin
      busy       = (state_q != IDLE);
      done       = (state_q == FIN);
      rd_en      = (state_q == READ);
      o_we       = (state_q == WRITE);
      acc_clr    = (state_q == LOAD) || (state_q == WRITE);
      relu_layer = ~layer_q[1];
      w_addr     = '0;
      a_addr     = '0;
      o_addr     = '0;
      o_wdata    = '0;
      if (rd_en) begin
         w_addr = w_base + ADDR_W'(j_q) * ADDR_W'(fan_in) + ADDR_W'(i_q);
         a_addr = {layer_q[0], i_q};
      end
      if (o_we) begin
         o_addr  = {~layer_q[0], j_q};
         o_wdata = mac_result;
      end
   end

   nn_mac_unit #(
      .DATA_W (DATA_W),
      .FRAC_W (FRAC_W),
      .ACC_W  (ACC_W)
   ) u_mac (
      .clk    (clk),
      .reset  (reset),
      .clr    (acc_clr),
      .en     (acc_en_q),
      .relu   (relu_layer),
      .w      (w_rdata),
      .a      (a_rdata),
      .result (mac_result)
   );

endmodule
`default_nettype wire
